// File: rtl/fifo_synch_1r1w_cnt.sv
// Synchronous 1-read/1-write FIFO with valid-ready input, valid-yumi registered output,
// arbitrary capacity, occupancy count, almost-full/empty flags, flush and sticky error.
module fifo_synch_1r1w_cnt #(
    parameter int WIDTH_P     = 32,
    parameter int CAP_P       = 8,
    parameter int AF_THRESH_P = CAP_P - 1,
    parameter int AE_THRESH_P = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [WIDTH_P-1:0]         data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [WIDTH_P-1:0]         data_o,
    input  logic                       yumi_i,
    input  logic                       flush_i,
    output logic [$clog2(CAP_P+1)-1:0] count_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic                       err_o
);
    localparam int PTR_W = $clog2(CAP_P);
    localparam int CNT_W = $clog2(CAP_P + 1);
    localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAP_P);
    localparam logic [CNT_W-1:0] AF_C  = CNT_W'(AF_THRESH_P);
    localparam logic [CNT_W-1:0] AE_C  = CNT_W'(AE_THRESH_P);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    logic [WIDTH_P-1:0] mem [CAP_P];
    logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d, rptr_nxt_s;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH_P-1:0] dout_q, dout_d;
    logic               err_q, err_d;
    logic               enq_s, deq_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(CAP_P - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Status outputs derived only from registered state.
    always_comb begin
        ready_o        = (count_q < CAP_C);
        valid_o        = (count_q != '0);
        almost_full_o  = (count_q >= AF_C);
        almost_empty_o = (count_q <= AE_C);
        count_o        = count_q;
        data_o         = dout_q;
        err_o          = err_q;
    end

    // Next-state computation; flush overrides any transfer in the same cycle.
    always_comb begin
        enq_s      = valid_i & ready_o & ~flush_i;
        deq_s      = yumi_i & valid_o & ~flush_i;
        rptr_nxt_s = ptr_inc(rptr_q);
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        dout_d     = dout_q;
        err_d      = err_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            if (enq_s) begin
                wptr_d = ptr_inc(wptr_q);
            end else begin
                wptr_d = wptr_q;
            end
            if (deq_s) begin
                rptr_d = rptr_nxt_s;
            end else begin
                rptr_d = rptr_q;
            end
            if (yumi_i & ~valid_o) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
            case ({enq_s, deq_s})
                2'b10: begin
                    count_d = count_q + ONE_C;
                    if (count_q == '0) begin
                        dout_d = data_i;
                    end else begin
                        dout_d = dout_q;
                    end
                end
                2'b01: begin
                    count_d = count_q - ONE_C;
                    dout_d  = mem[rptr_nxt_s];
                end
                // With a single entry the next head is the word being written now.
                2'b11: begin
                    count_d = count_q;
                    if (count_q == ONE_C) begin
                        dout_d = data_i;
                    end else begin
                        dout_d = mem[rptr_nxt_s];
                    end
                end
                default: begin
                    count_d = count_q;
                    dout_d  = dout_q;
                end
            endcase
        end
    end

    // Control and output-buffer registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    // Storage array, intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            mem[wptr_q] <= data_i;
        end
    end
endmodule

// File: doc/fifo_synch_1r1w_cnt.md
Name: fifo_synch_1r1w_cnt

Overview:
Parametrised synchronous single-read/single-write FIFO: the next generation of the team's 1r1w queue. Takes valid-ready input and gives valid-yumi output from a registered output buffer. Adds any capacity ≥2 (not only powers of two), an occupancy count, almost-full/almost-empty flags, synchronous flush and a sticky protocol-error flag. Intended as a drop-in buffer between pipeline stages and for memory request queues.

Parameters:
WIDTH_P, 32, data word width in bits (≥1)
CAP_P, 8, capacity in entries (≥2, any integer)
AF_THRESH_P, CAP_P-1, almost_full_o asserts when count ≥ AF_THRESH_P (1..CAP_P)
AE_THRESH_P, 1, almost_empty_o asserts when count ≤ AE_THRESH_P (0..CAP_P-1)

Ports:
clk_i  in  1  clock, all state on rising edge
reset_n_i  in  1  asynchronous, active-low reset
data_i  in  WIDTH_P  enqueue data
valid_i  in  1  producer has data
ready_o  out  1  FIFO can accept (count < CAP_P)
valid_o  out  1  data_o holds head entry (count > 0)
data_o  out  WIDTH_P  head entry, driven from output register
yumi_i  in  1  consumer takes head this cycle; legal only when valid_o=1
flush_i  in  1  synchronous clear of all contents
count_o  out  $clog2(CAP_P+1)  current occupancy
almost_full_o  out  1  count_o ≥ AF_THRESH_P
almost_empty_o  out  1  count_o ≤ AE_THRESH_P
err_o  out  1  sticky: yumi_i seen while valid_o=0

Behaviour:
- Interface: one clock, clk_i; reset_n_i is asynchronous, active-low.
- Reset (async assert, any cycle including mid-transfer): read/write pointers=0, count=0, output buffer=0, err=0. So ready_o=1, valid_o=0, data_o=0, count_o=0, almost_full_o=(AF_THRESH_P==0 ? 1 : 0), almost_empty_o=1, err_o=0. Storage array is not reset.
- enqueue = valid_i & ready_o; dequeue = yumi_i & valid_o.
- Occupancy is held in a count register; full/empty come only from count, never from pointer comparison. ready_o, valid_o and the flags are combinational from registered state only (no input→output paths).
- Pointers are $clog2(CAP_P) bits wide. Each wraps from CAP_P-1 to 0 explicitly; no power-of-two assumption.
- Latency: a word enqueued into an empty FIFO appears on data_o with valid_o=1 on the next cycle. There is no same-cycle bypass.
- Enqueue only: mem[wptr]←data_i; wptr advances; count+1. If count was 0, output buffer←data_i.
- Dequeue only: rptr advances; count-1. Output buffer←mem[rptr+1 wrapped]; the value is don't-care if the new count is 0.
- Simultaneous enqueue+dequeue: count unchanged and both pointers advance. If count==1, output buffer←data_i; otherwise output buffer←mem[rptr+1 wrapped].
- Full (count==CAP_P): ready_o=0 even if yumi_i=1 that cycle, so no simultaneous pass-through at full. valid_i is ignored.
- Empty: valid_o=0, and data_o holds its last value.
- flush_i=1 has priority over all other activity. Next cycle: pointers=0, count=0, err=0, valid_o=0. Any enqueue or dequeue in the flush cycle is discarded. The output buffer is not cleared.
- Protocol error: yumi_i=1 while valid_o=0 sets err_o on the next edge. State is otherwise unchanged. err_o is cleared only by reset or flush.
- valid_o must not drop without a dequeue, and data_o must be stable while valid_o=1 and yumi_i=0.

Test Plan:
(Use WIDTH_P=8, CAP_P=5, AF_THRESH_P=4, AE_THRESH_P=1 unless stated.)
- Reset, then enqueue 0x11,0x22,0x33 on consecutive cycles with yumi_i=0 → valid_o rises the cycle after 0x11 with data_o=0x11; count_o=3; almost_empty_o=0 once count=2.
- Fill 5 words 0xA0..0xA4 → count_o=5, ready_o=0, almost_full_o=1 from count=4. Hold valid_i=1 with 0xFF → not accepted. Drain with yumi_i=1 → 0xA0..0xA4 in order, then valid_o=0.
- Wrap on non-power-of-two depth: 12 words streamed with random valid_i/yumi_i gaps → output order exact, pointers wrap at 4→0, count_o always matches the scoreboard.
- count=1 holding 0x5A; same cycle valid_i=1 with 0x6B and yumi_i=1 → next cycle data_o=0x6B, valid_o=1, count_o=1.
- count=3, assert flush_i together with valid_i=1 → next cycle count_o=0, valid_o=0, ready_o=1; the flushed-cycle word never appears. Pulse yumi_i with valid_o=0 → err_o=1 and stays 1 until the next flush or reset.
- Assert reset_n_i=0 mid-stream between clock edges → outputs take reset values immediately (valid_o=0, count_o=0, ready_o=1, err_o=0). After release, a new word 0x77 is dequeued first.
